instr_encoder: RTL
==================

// Module: instr_encoder
// PURPOSE
//   Inverse of the R-type field decode: packs opcode/rs1/rs2/rd/ALU-function fields into a
//   32-bit RV32 R-type word. Emits each word with a sequential write address for
//   instruction-memory preload and test-program generation.
//   One-entry output register; valid/ready handshake on both sides.
// PARAMETERS
//   ADDR_W     6   width of write address; address space = 2**ADDR_W words
//   BASE_ADDR  0   first address issued after reset/clear (ADDR_W bits)
// PORTS
//   clk          in   1   single clock, rising edge
//   rst_n        in   1   asynchronous active-low reset
//   clear        in   1   sync: drop pending word, rewind pointer to BASE_ADDR, clear full
//   in_valid     in   1   field set presented
//   in_ready     out  1   encoder can accept this cycle
//   opcode       in   7   instr[6:0]
//   rd_add       in   5   instr[11:7]
//   rs1_add      in   5   instr[19:15]
//   rs2_add      in   5   instr[24:20]
//   ins_for_ALU  in   10  {funct7, funct3}: [9:3]->instr[31:25], [2:0]->instr[14:12]
//   out_valid    out  1   out_instr/out_addr hold a word
//   out_ready    in   1   sink accepts the word
//   out_instr    out  32  encoded instruction
//   out_addr     out  ADDR_W  memory address for out_instr
//   full         out  1   address space exhausted (last address issued)
//   word_count   out  ADDR_W+1  words accepted since reset/clear
// BEHAVIOUR
//   Reset (rst_n=0, async): out_valid=0, out_instr=0, out_addr=0, full=0, word_count=0,
//     wr_ptr=BASE_ADDR, state=EMPTY. in_ready is combinational, so it is 0 during reset.
//   in_ready = rst_n & !full & (!out_valid | out_ready)   (combinational, no skid buffer)
//   Accept = in_valid & in_ready. At that edge:
//     out_instr <= {ins_for_ALU[9:3], rs2_add, rs1_add, ins_for_ALU[2:0], rd_add, opcode};
//     out_addr <= wr_ptr; wr_ptr <= wr_ptr+1; word_count++; out_valid <= 1.
//   Latency: word visible 1 cycle after accept. Throughput 1 word/cycle while out_ready=1.
//   Output drain: out_valid & out_ready with no accept -> out_valid <= 0.
//   Accept and drain in the same cycle -> new word replaces old; out_valid stays 1.
//   out_instr/out_addr are held stable while out_valid & !out_ready.
//   States:
//     EMPTY      out_valid=0, full=0. Accept -> LOADED.
//     LOADED     out_valid=1. Drain w/o accept -> EMPTY. Accept of last address -> EXHAUSTED.
//     EXHAUSTED  full=1, in_ready=0. Last word stays until drained; no further accepts.
//   Last address = wr_ptr==2**ADDR_W-1 at accept. At that accept full <= 1 and wr_ptr
//     wraps to 0 internally; no further address is issued until clear.
//   word_count saturates at 2**ADDR_W (cannot exceed it because full blocks accepts).
//   clear has priority over accept and drain in the same cycle:
//     in_valid is ignored; out_valid<=0; wr_ptr<=BASE_ADDR; full<=0; word_count<=0; ->EMPTY.
//   No field validation: any opcode is packed verbatim.
//   Reset mid-transfer aborts immediately; the pending word is lost.
// TESTING
//   T1 reset: rst_n=0 mid-cycle -> all outputs 0 at once, in_ready=0; release -> in_ready=1.
//   T2 encode sub x5,x6,x7: opcode=7'h33, rd=5, rs1=6, rs2=7, ins_for_ALU=10'h100
//      -> next cycle out_valid=1, out_instr=32'h407302B3, out_addr=0.
//   T3 backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0,
//      out_instr/out_addr stable, word_count=1; out_ready=1 -> next word at addr 1.
//   T4 streaming: 4 back-to-back words, out_ready=1 -> out_addr 0,1,2,3 on consecutive cycles,
//      word_count=4.
//   T5 exhaustion (ADDR_W=2): 4 accepts -> full=1, in_ready=0, 5th in_valid ignored.
//      Drain, then clear -> full=0, word_count=0, next word at out_addr=BASE_ADDR.
//   T6 clear collision: clear=1 with in_valid=1 and out_valid=1 -> out_valid=0, no accept,
//      word_count=0.

Source files
------------

// File: rtl/instr_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : instr_encoder                                                 |
// | Purpose  : Packs R-type fields into RV32 words with sequential addresses |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module instr_encoder #(
  parameter int                ADDR_W    = 6,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [6:0]        opcode,
  input  logic [4:0]        rd_add,
  input  logic [4:0]        rs1_add,
  input  logic [4:0]        rs2_add,
  input  logic [9:0]        ins_for_ALU,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_addr,
  output logic              full,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] c_last_addr = '1;
  localparam logic [ADDR_W:0]   c_max_count = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_EMPTY     = 2'd0,
    S_LOADED    = 2'd1,
    S_EXHAUSTED = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic              r_full;
  logic [ADDR_W:0]   r_word_count;

  logic              w_accept;
  logic [31:0]       w_word;

  // No skid buffer: a new word is taken only if the output slot frees this cycle.
  assign in_ready = rst_n & ~r_full & (~r_out_valid | out_ready);
  assign w_accept = in_valid & in_ready;
  assign w_word   = {ins_for_ALU[9:3], rs2_add, rs1_add, ins_for_ALU[2:0], rd_add, opcode};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_EMPTY;
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_addr   <= '0;
      r_wr_ptr     <= BASE_ADDR;
      r_full       <= 1'b0;
      r_word_count <= '0;
    end else if (clear) begin
      r_state      <= S_EMPTY;
      r_out_valid  <= 1'b0;
      r_wr_ptr     <= BASE_ADDR;
      r_full       <= 1'b0;
      r_word_count <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_instr <= w_word;
      r_out_addr  <= r_wr_ptr;
      r_wr_ptr    <= r_wr_ptr + ADDR_W'(1);
      if (r_word_count != c_max_count) begin
        r_word_count <= r_word_count + (ADDR_W+1)'(1);
      end
      // Issuing the top address exhausts the space; the pointer wraps but stays unused.
      if (r_wr_ptr == c_last_addr) begin
        r_full  <= 1'b1;
        r_state <= S_EXHAUSTED;
      end else begin
        r_state <= S_LOADED;
      end
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
      if (r_state != S_EXHAUSTED) begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_instr  = r_out_instr;
  assign out_addr   = r_out_addr;
  assign full       = r_full;
  assign word_count = r_word_count;

endmodule
`default_nettype wire
